// File: rtl/arcade_input_pkg.sv
// Shared types and constants for the arcade input conditioning stage:
// credit FSM states, PS/2 scan codes and JOY vector bit positions.
package arcade_input_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    COIN     = 3'd1,
    GAP      = 3'd2,
    START    = 3'd3,
    WAIT_REL = 3'd4
  } credit_state_t;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  localparam logic [7:0] KEY_UP    = 8'h75;
  localparam logic [7:0] KEY_DOWN  = 8'h72;
  localparam logic [7:0] KEY_LEFT  = 8'h6B;
  localparam logic [7:0] KEY_RIGHT = 8'h74;
  localparam logic [7:0] KEY_JUMP  = 8'h29;
  localparam logic [7:0] KEY_FIRE  = 8'h14;
  localparam logic [7:0] KEY_F1    = 8'h05;
  localparam logic [7:0] KEY_F2    = 8'h06;

  localparam int JOY_RIGHT = 0;
  localparam int JOY_LEFT  = 1;
  localparam int JOY_DOWN  = 2;
  localparam int JOY_UP    = 3;
  localparam int JOY_FIRE  = 4;
  localparam int JOY_JUMP  = 5;
  localparam int JOY_START = 6;
  localparam int JOY_COIN  = 7;

  typedef struct packed {
    logic up;
    logic down;
    logic left;
    logic right;
    logic jump;
    logic fire;
    logic f1;
    logic f2;
  } key_latch_t;

endpackage

// File: rtl/arcade_input_ctrl_credit_sequencer.sv
// Credit sequencer: one request edge yields a COIN_CYCLES coin pulse, a GAP_CYCLES gap, then a
// START_CYCLES start1 pulse; outputs registered, first pulse one cycle after the request edge.
module credit_sequencer
  import arcade_input_pkg::*;
#(
  parameter int COIN_CYCLES  = 3_000_000,
  parameter int GAP_CYCLES   = 1_500_000,
  parameter int START_CYCLES = 3_000_000,
  parameter int CNT_W        = 22
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic req,
  output logic coin_seq,
  output logic start_seq
);

  localparam logic [CNT_W-1:0] COIN_LOAD  = CNT_W'(COIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] START_LOAD = CNT_W'(START_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  credit_state_t    state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             coin_q;
  logic             start_q;
  logic             req_q;
  logic             req_rise;
  logic             cnt_zero;

  assign req_rise  = req & ~req_q;
  assign cnt_zero  = (cnt_q == '0);
  assign coin_seq  = coin_q;
  assign start_seq = start_q;

  // req_q resets high so a request already held when reset releases is not a fresh press.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      coin_q  <= 1'b0;
      start_q <= 1'b0;
      req_q   <= 1'b1;
    end else begin
      req_q <= req;
      case (state_q)
        IDLE: begin
          coin_q  <= 1'b0;
          start_q <= 1'b0;
          if (req_rise) begin
            state_q <= COIN;
            cnt_q   <= COIN_LOAD;
            coin_q  <= 1'b1;
          end
        end
        COIN: begin
          if (cnt_zero) begin
            state_q <= GAP;
            cnt_q   <= GAP_LOAD;
            coin_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        GAP: begin
          if (cnt_zero) begin
            state_q <= START;
            cnt_q   <= START_LOAD;
            start_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        START: begin
          if (cnt_zero) begin
            state_q <= WAIT_REL;
            start_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        WAIT_REL: begin
          if (!req) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          coin_q  <= 1'b0;
          start_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/arcade_input_ctrl.sv
// PS/2 key decode, joystick merge and credit sequencing into the registered JOY vector.
// Key event to joy_out: 2 clk_sys; joystick bit to joy_out: 1 clk_sys; no backpressure.
module arcade_input_ctrl
  import arcade_input_pkg::*;
#(
  parameter int COIN_CYCLES  = 3_000_000,
  parameter int GAP_CYCLES   = 1_500_000,
  parameter int START_CYCLES = 3_000_000,
  parameter int CNT_W        = 22
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [64:0] ps2_key,
  input  logic [15:0] joystick_0,
  input  logic [15:0] joystick_1,
  output logic [7:0]  joy_out
);

  logic       toggle_q;
  logic       armed_q;
  key_latch_t keys_q;
  logic [7:0] joy_q;
  logic [7:0] joy_d;

  logic        key_evt;
  logic        key_valid;
  logic        key_pressed;
  logic        key_ext;
  logic [7:0]  key_code;
  logic [15:0] joy_any;
  logic [7:0]  unused_joy_hi;
  logic        req;
  logic        coin_seq;
  logic        start_seq;

  assign key_evt     = armed_q && (ps2_key[64] != toggle_q);
  assign key_pressed = (ps2_key[15:8] != PS2_BREAK);
  assign key_ext     = key_pressed ? (ps2_key[15:8] == PS2_EXT) : (ps2_key[23:16] == PS2_EXT);
  // Multi-byte sequences (PrtScr/Pause) carry upper bytes and must not alias onto mapped keys.
  assign key_valid   = key_evt && (ps2_key[63:24] == '0);
  assign key_code    = ps2_key[7:0];

  assign joy_any       = joystick_0 | joystick_1;
  assign unused_joy_hi = joy_any[15:8];
  assign req           = keys_q.f1 | joy_any[JOY_START];

  // The first cycle after reset only samples the toggle so a stale level is not seen as an event.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      toggle_q <= 1'b0;
      armed_q  <= 1'b0;
      keys_q   <= '0;
    end else if (!armed_q) begin
      toggle_q <= ps2_key[64];
      armed_q  <= 1'b1;
    end else begin
      if (key_evt) begin
        toggle_q <= ps2_key[64];
      end
      if (key_valid) begin
        case (key_code)
          KEY_UP:    keys_q.up    <= key_pressed;
          KEY_DOWN:  keys_q.down  <= key_pressed;
          KEY_LEFT:  keys_q.left  <= key_pressed;
          KEY_RIGHT: keys_q.right <= key_pressed;
          KEY_JUMP:  if (!key_ext) keys_q.jump <= key_pressed;
          KEY_FIRE:  if (!key_ext) keys_q.fire <= key_pressed;
          KEY_F1:    if (!key_ext) keys_q.f1   <= key_pressed;
          KEY_F2:    if (!key_ext) keys_q.f2   <= key_pressed;
          default: ;
        endcase
      end
    end
  end

  credit_sequencer #(
    .COIN_CYCLES (COIN_CYCLES),
    .GAP_CYCLES  (GAP_CYCLES),
    .START_CYCLES(START_CYCLES),
    .CNT_W       (CNT_W)
  ) u_credit (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .req      (req),
    .coin_seq (coin_seq),
    .start_seq(start_seq)
  );

  // Raw start never reaches the core; start1 comes only from the sequencer.
  always_comb begin
    joy_d            = '0;
    joy_d[JOY_RIGHT] = keys_q.right | joy_any[JOY_RIGHT];
    joy_d[JOY_LEFT]  = keys_q.left  | joy_any[JOY_LEFT];
    joy_d[JOY_DOWN]  = keys_q.down  | joy_any[JOY_DOWN];
    joy_d[JOY_UP]    = keys_q.up    | joy_any[JOY_UP];
    joy_d[JOY_FIRE]  = keys_q.fire  | joy_any[JOY_FIRE];
    joy_d[JOY_JUMP]  = keys_q.jump  | joy_any[JOY_JUMP];
    joy_d[JOY_START] = start_seq;
    joy_d[JOY_COIN]  = coin_seq | keys_q.f2 | joy_any[JOY_COIN];
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      joy_q <= '0;
    end else begin
      joy_q <= joy_d;
    end
  end

  assign joy_out = joy_q;

endmodule

// File: tb/tb_arcade_input_ctrl.sv
// Scoreboard bench for arcade_input_ctrl: directed scenarios plus a randomized phase,
// expectations from a cycle-level behavioural model of the key, joystick and credit rules.
module tb_arcade_input_ctrl;

  localparam int C = 4;
  localparam int G = 2;
  localparam int S = 3;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic [64:0] ps2_key;
  logic [15:0] joystick_0;
  logic [15:0] joystick_1;
  logic [7:0]  joy_out;

  always #5 clk_sys = ~clk_sys;

  arcade_input_ctrl #(
    .COIN_CYCLES (C),
    .GAP_CYCLES  (G),
    .START_CYCLES(S),
    .CNT_W       (3)
  ) dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .ps2_key   (ps2_key),
    .joystick_0(joystick_0),
    .joystick_1(joystick_1),
    .joy_out   (joy_out)
  );

  typedef struct {
    int         cyc;
    logic [7:0] exp;
  } sb_t;

  sb_t sbq[$];
  int  total = 0;
  int  bad = 0;
  int  cyc_cnt = 0;

  // Reference model state
  logic [7:0] m_out;
  bit m_first, m_busy, m_req_prev, m_tog;
  bit m_up, m_down, m_left, m_right, m_jump, m_fire, m_f1, m_f2;
  int m_n = 0;
  int m_t0 = 0;

  logic [63:0] ktab [0:21];

  initial forever begin
    @(posedge clk_sys);
    cyc_cnt++;
  end

  // Monitor: joy_out is presented every cycle; each negedge consumes the entry for that cycle.
  initial begin
    sb_t e;
    forever begin
      @(negedge clk_sys);
      while (sbq.size() > 0 && sbq[0].cyc <= cyc_cnt) begin
        e = sbq.pop_front();
        total++;
        if (e.cyc != cyc_cnt || joy_out !== e.exp) begin
          bad++;
          $display("FAIL joy_out cyc=%0d (entry %0d) got=%h want=%h", cyc_cnt, e.cyc, joy_out, e.exp);
        end
      end
    end
  end

  task automatic apply_key(input logic [63:0] w);
    bit rel, ext, prs;
    if (w[63:24] != 40'd0) return;
    rel = (w[15:8] == 8'hF0);
    prs = !rel;
    ext = rel ? (w[23:16] == 8'hE0) : (w[15:8] == 8'hE0);
    case (w[7:0])
      8'h75: m_up = prs;
      8'h72: m_down = prs;
      8'h6B: m_left = prs;
      8'h74: m_right = prs;
      8'h29: if (!ext) m_jump = prs;
      8'h14: if (!ext) m_fire = prs;
      8'h05: if (!ext) m_f1 = prs;
      8'h06: if (!ext) m_f2 = prs;
      default: ;
    endcase
  endtask

  // One clock edge of the model, using the inputs currently driven.
  task automatic model_edge();
    logic [15:0] j;
    bit req, coin_t, start_t;
    int d;
    if (!reset_n) begin
      m_first = 1; m_busy = 0; m_req_prev = 0; m_tog = 0;
      {m_up, m_down, m_left, m_right, m_jump, m_fire, m_f1, m_f2} = '0;
      m_out = 8'h00;
      return;
    end
    m_n++;
    j = joystick_0 | joystick_1;
    req = m_f1 | j[6];
    d = m_n - m_t0;
    coin_t  = m_busy && d >= 1 && d <= C;
    start_t = m_busy && d >= C + G + 1 && d <= C + G + S;
    m_out = {coin_t | m_f2 | j[7], start_t, m_jump | j[5], m_fire | j[4],
             m_up | j[3], m_down | j[2], m_left | j[1], m_right | j[0]};
    if (m_first) begin
      m_tog = ps2_key[64];
    end else if (ps2_key[64] != m_tog) begin
      m_tog = ps2_key[64];
      apply_key(ps2_key[63:0]);
    end
    if (m_busy) begin
      if (d >= C + G + S + 1 && !req) m_busy = 0;
    end else if (!m_first && req && !m_req_prev) begin
      m_busy = 1;
      m_t0 = m_n;
    end
    m_req_prev = req;
    m_first = 0;
  endtask

  // Push the expectation for the edge just taken, advance the model on the current inputs.
  task automatic tick();
    sb_t e;
    e.cyc = cyc_cnt;
    e.exp = reset_n ? m_out : 8'h00;
    sbq.push_back(e);
    model_edge();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic key_evt(input logic [63:0] w);
    ps2_key = {~ps2_key[64], w};
    tick();
  endtask

  initial begin
    ktab[0]  = 64'h0029; ktab[1]  = 64'hF029; ktab[2]  = 64'h0014; ktab[3]  = 64'hF014;
    ktab[4]  = 64'hE014; ktab[5]  = 64'hE0F014; ktab[6] = 64'hE075; ktab[7]  = 64'hE0F075;
    ktab[8]  = 64'h0075; ktab[9]  = 64'hF075; ktab[10] = 64'hE072; ktab[11] = 64'hE0F072;
    ktab[12] = 64'hE06B; ktab[13] = 64'hE0F06B; ktab[14] = 64'hE074; ktab[15] = 64'hE0F074;
    ktab[16] = 64'h0005; ktab[17] = 64'hF005; ktab[18] = 64'h0006; ktab[19] = 64'hF006;
    ktab[20] = 64'h0000_0001_0000_0075; ktab[21] = 64'h001C;

    reset_n = 1'b0;
    ps2_key = {1'b1, 64'h0029};
    joystick_0 = '0;
    joystick_1 = '0;
    model_edge();
    @(posedge clk_sys);
    #1;

    // Reset held with a stale toggle level
    idle(10);
    reset_n = 1'b1;
    idle(4);

    // Jump press/release
    key_evt(64'h0029); idle(3);
    key_evt(64'hF029); idle(3);

    // Extended up press/release, then a PrtScr-style word carrying code 75
    key_evt(64'hE075); idle(3);
    key_evt(64'hE0F075); idle(3);
    key_evt(64'h0000_0001_0000_0075); idle(3);

    // Joystick start held, released, pressed again
    joystick_0[6] = 1'b1; idle(20);
    joystick_0[6] = 1'b0; idle(3);
    joystick_0[6] = 1'b1; idle(20);
    joystick_0[6] = 1'b0; idle(3);

    // Second request during GAP and F2 coin overlapping the sequence
    joystick_0[6] = 1'b1; tick();
    joystick_0[6] = 1'b0; idle(3);
    joystick_0[6] = 1'b1; tick();
    key_evt(64'h0006); idle(2);
    key_evt(64'hF006); idle(10);
    joystick_0[6] = 1'b0; idle(3);

    // Reset dropped during START with request still held afterwards
    joystick_1[6] = 1'b1; idle(8);
    reset_n = 1'b0; idle(2);
    reset_n = 1'b1; idle(10);
    joystick_1[6] = 1'b0; idle(2);
    joystick_1[6] = 1'b1; idle(12);
    joystick_1[6] = 1'b0; idle(3);

    // F1 key as start request, plus direct joystick bits
    key_evt(64'h0005); idle(12);
    key_evt(64'hF005); idle(3);
    joystick_1 = 16'hFF3F; idle(2);
    joystick_1 = 16'h0000; idle(2);

    // Randomized phase
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(5) == 0) begin
        ps2_key = {~ps2_key[64], ktab[$urandom_range(21)]};
      end else if ($urandom_range(7) == 0) begin
        ps2_key[63:0] = {$urandom, $urandom};
      end
      if ($urandom_range(3) == 0)
        joystick_0 = 16'($urandom) & 16'hFF3F;
      if ($urandom_range(15) == 0)
        joystick_1[6] = ~joystick_1[6];
      if ($urandom_range(9) == 0)
        joystick_1 = (16'($urandom) & 16'hFFBF & (($urandom_range(3) == 0) ? 16'hFFFF : 16'hFF7F))
                     | (joystick_1 & 16'h0040);
      tick();
    end
    joystick_0 = '0;
    joystick_1 = '0;
    idle(20);

    @(negedge clk_sys);
    #1;
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d want=0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
